// File: rtl/wb_stage_pkg.sv
// Shared constants for the write-back stage: instruction decode fields,
// syscall service codes and the syscall FSM state encoding.
package wb_stage_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_PAUSE  = 2'd1,
    ST_HALT   = 2'd2,
    ST_RESUME = 2'd3
  } state_t;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] FN_MFHI    = 6'h10;
  localparam logic [5:0] FN_MFLO    = 6'h12;

  localparam logic [31:0] SC_PRINT_INT = 32'd1;
  localparam logic [31:0] SC_PRINT_HEX = 32'd34;
  localparam logic [31:0] SC_EXIT      = 32'd10;
  localparam logic [31:0] SC_PAUSE     = 32'd50;

endpackage

// File: rtl/wb_stage_if.sv
// MEM/WB bundle feeding the write-back stage. The stage has no ready path:
// an instruction is consumed on every edge where valid is high and the stage
// is in RUN; upstream holds the bundle while stall is high.
interface wb_stage_if;
  logic        valid;
  logic [31:0] IR;
  logic [31:0] PC;
  logic [31:0] R1;
  logic [31:0] R2;
  logic [31:0] RD1;
  logic [31:0] RD2;
  logic [4:0]  WbRegNum;
  logic        RegWrite;
  logic        LOWrite;
  logic        HIWrite;
  logic        JAL;
  logic        SYSCALL;

  modport master (
    output valid, IR, PC, R1, R2, RD1, RD2, WbRegNum,
           RegWrite, LOWrite, HIWrite, JAL, SYSCALL
  );

  modport slave (
    input  valid, IR, PC, R1, R2, RD1, RD2, WbRegNum,
           RegWrite, LOWrite, HIWrite, JAL, SYSCALL
  );
endinterface

// File: rtl/wb_syscall_fsm.sv
// Syscall control FSM: RUN / PAUSE / HALT / RESUME, plus the stall and halt
// decode and the live qualifier used to gate every write-back side effect.
module wb_syscall_fsm
  import wb_stage_pkg::*;
(
  input  logic        clk,
  input  logic        CLR,
  input  logic        valid,
  input  logic        SYSCALL,
  input  logic [31:0] RD1,
  input  logic        go,
  output state_t      state,
  output logic        live,
  output logic        stall,
  output logic        halt
);

  state_t state_next;

  always_ff @(posedge clk) begin
    if (CLR) state <= ST_RUN;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    live       = valid && (state == ST_RUN);
    stall      = 1'b0;
    halt       = 1'b0;
    case (state)
      ST_RUN: begin
        if (live && SYSCALL) begin
          if (RD1 == SC_EXIT)       state_next = ST_HALT;
          else if (RD1 == SC_PAUSE) state_next = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        stall = 1'b1;
        if (go) state_next = ST_RESUME;
      end
      // Upstream is released here but the held syscall is still on the bus,
      // so this one cycle keeps live low to avoid re-executing it.
      ST_RESUME: state_next = ST_RUN;
      ST_HALT: begin
        stall = 1'b1;
        halt  = 1'b1;
      end
      default: state_next = ST_RUN;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Pipeline write-back stage: register-file write port, HI/LO registers,
// syscall display latch and retire/cycle statistics.
module wb_stage
  import wb_stage_pkg::*;
(
  input  logic            clk,
  input  logic            CLR,
  wb_stage_if.slave       bus,
  input  logic            go,
  output logic            rf_we,
  output logic [4:0]      rf_waddr,
  output logic [31:0]     rf_wdata,
  output logic [31:0]     hi,
  output logic [31:0]     lo,
  output logic [31:0]     disp,
  output logic            halt,
  output logic            stall,
  output logic [31:0]     retire_cnt,
  output logic [31:0]     cycle_cnt,
  output state_t          state
);

  logic       live;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       unused_ir;

  assign opcode    = bus.IR[31:26];
  assign funct     = bus.IR[5:0];
  assign unused_ir = ^bus.IR[25:6];

  wb_syscall_fsm u_fsm (
    .clk     (clk),
    .CLR     (CLR),
    .valid   (bus.valid),
    .SYSCALL (bus.SYSCALL),
    .RD1     (bus.RD1),
    .go      (go),
    .state   (state),
    .live    (live),
    .stall   (stall),
    .halt    (halt)
  );

  assign rf_we    = live && bus.RegWrite && (bus.WbRegNum != 5'd0);
  assign rf_waddr = bus.WbRegNum;

  // mfhi/mflo read the registered HI/LO, so a same-cycle HI/LO write is not
  // forwarded.
  always_comb begin
    rf_wdata = bus.R1;
    if (bus.JAL)                                         rf_wdata = bus.PC + 32'd4;
    else if (opcode == OP_LW)                            rf_wdata = bus.R2;
    else if (opcode == OP_SPECIAL && funct == FN_MFHI)   rf_wdata = hi;
    else if (opcode == OP_SPECIAL && funct == FN_MFLO)   rf_wdata = lo;
  end

  always_ff @(posedge clk) begin
    if (CLR) begin
      hi         <= '0;
      lo         <= '0;
      disp       <= '0;
      retire_cnt <= '0;
      cycle_cnt  <= '0;
    end else begin
      if (live && bus.LOWrite) lo <= bus.R1;
      if (live && bus.HIWrite) hi <= bus.R2;
      if (live && bus.SYSCALL &&
          (bus.RD1 == SC_PRINT_INT || bus.RD1 == SC_PRINT_HEX))
        disp <= bus.RD2;
      if (live) retire_cnt <= retire_cnt + 32'd1;
      if (state != ST_HALT) cycle_cnt <= cycle_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: write-back muxing, HI/LO timing, syscall
// pause/resume/halt sequencing, counters and reset priority.
module tb_wb_stage;
  import wb_stage_pkg::*;

  logic        clk;
  logic        CLR;
  logic        go;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] disp;
  logic        halt;
  logic        stall;
  logic [31:0] retire_cnt;
  logic [31:0] cycle_cnt;
  state_t      state;

  int n_checks;
  int n_fail;
  logic [31:0] exp_cyc;
  logic [31:0] exp_ret;

  wb_stage_if bus ();

  wb_stage dut (
    .clk        (clk),
    .CLR        (CLR),
    .bus        (bus),
    .go         (go),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .hi         (hi),
    .lo         (lo),
    .disp       (disp),
    .halt       (halt),
    .stall      (stall),
    .retire_cnt (retire_cnt),
    .cycle_cnt  (cycle_cnt),
    .state      (state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic idle();
    bus.valid    = 1'b0;
    bus.IR       = '0;
    bus.PC       = '0;
    bus.R1       = '0;
    bus.R2       = '0;
    bus.RD1      = '0;
    bus.RD2      = '0;
    bus.WbRegNum = '0;
    bus.RegWrite = 1'b0;
    bus.LOWrite  = 1'b0;
    bus.HIWrite  = 1'b0;
    bus.JAL      = 1'b0;
    bus.SYSCALL  = 1'b0;
  endtask

  task automatic step(input int cinc, input int rinc);
    @(posedge clk);
    #1;
    exp_cyc = exp_cyc + 32'(cinc);
    exp_ret = exp_ret + 32'(rinc);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk_ctrl(input string tag, input state_t st, input logic st_stall, input logic st_halt);
    chk({tag, "_state"}, 32'(state), 32'(st));
    chk({tag, "_stall"}, 32'(stall), 32'(st_stall));
    chk({tag, "_halt"},  32'(halt),  32'(st_halt));
  endtask

  task automatic chk_cnt(input string tag);
    chk({tag, "_cycle"},  cycle_cnt,  exp_cyc);
    chk({tag, "_retire"}, retire_cnt, exp_ret);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    exp_cyc  = '0;
    exp_ret  = '0;
    go  = 1'b0;
    CLR = 1'b1;
    idle();

    step(0, 0);
    step(0, 0);
    chk_ctrl("rst", ST_RUN, 1'b0, 1'b0);
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    chk("rst_disp", disp, 32'h0);
    chk_cnt("rst");
    CLR = 1'b0;

    // lw to $8
    bus.valid = 1'b1; bus.RegWrite = 1'b1; bus.WbRegNum = 5'd8;
    bus.IR = {OP_LW, 26'h0}; bus.R1 = 32'h1111_1111; bus.R2 = 32'hDEAD_BEEF;
    settle();
    chk("lw_we", 32'(rf_we), 32'h1);
    chk("lw_waddr", 32'(rf_waddr), 32'd8);
    chk("lw_wdata", rf_wdata, 32'hDEAD_BEEF);
    step(1, 1);

    bus.WbRegNum = 5'd0;
    settle();
    chk("lw_r0_we", 32'(rf_we), 32'h0);
    step(1, 1);

    bus.WbRegNum = 5'd8; bus.valid = 1'b0;
    settle();
    chk("invalid_we", 32'(rf_we), 32'h0);
    step(1, 0);

    // jal
    idle();
    bus.valid = 1'b1; bus.RegWrite = 1'b1; bus.JAL = 1'b1; bus.WbRegNum = 5'd31;
    bus.PC = 32'h0040_0010; bus.IR = 32'h0C00_0000; bus.R1 = 32'h5;
    settle();
    chk("jal_we", 32'(rf_we), 32'h1);
    chk("jal_waddr", 32'(rf_waddr), 32'd31);
    chk("jal_wdata", rf_wdata, 32'h0040_0014);
    step(1, 1);
    chk_cnt("jal");

    // mult: LO=5, HI=7
    idle();
    bus.valid = 1'b1; bus.LOWrite = 1'b1; bus.HIWrite = 1'b1;
    bus.IR = 32'h0109_0018; bus.R1 = 32'd5; bus.R2 = 32'd7;
    settle();
    chk("mult_wdata", rf_wdata, 32'd5);
    step(1, 1);
    chk("mult_hi", hi, 32'd7);
    chk("mult_lo", lo, 32'd5);

    // mfhi while HI is being rewritten: must see the old HI
    idle();
    bus.valid = 1'b1; bus.RegWrite = 1'b1; bus.WbRegNum = 5'd2;
    bus.IR = 32'h0000_1010; bus.R1 = 32'h0000_AAAA; bus.R2 = 32'h0000_0099;
    bus.HIWrite = 1'b1;
    settle();
    chk("mfhi_wdata", rf_wdata, 32'd7);
    step(1, 1);
    chk("mfhi_hi_upd", hi, 32'h99);
    chk("mfhi_lo_keep", lo, 32'd5);

    idle();
    bus.valid = 1'b1; bus.RegWrite = 1'b1; bus.WbRegNum = 5'd3;
    bus.IR = 32'h0000_1812; bus.R1 = 32'h0000_AAAA; bus.R2 = 32'h0000_BBBB;
    settle();
    chk("mflo_wdata", rf_wdata, 32'd5);
    step(1, 1);

    idle();
    bus.valid = 1'b1; bus.LOWrite = 1'b1; bus.R1 = 32'h55; bus.R2 = 32'h66;
    step(1, 1);
    chk("lo_only_lo", lo, 32'h55);
    chk("lo_only_hi", hi, 32'h99);

    // display syscalls; go in RUN has no effect
    idle();
    bus.valid = 1'b1; bus.SYSCALL = 1'b1; bus.RD1 = 32'd34; bus.RD2 = 32'h1234;
    go = 1'b1;
    step(1, 1);
    go = 1'b0;
    chk("sc34_disp", disp, 32'h1234);
    chk_ctrl("sc34", ST_RUN, 1'b0, 1'b0);

    bus.RD1 = 32'd5; bus.RD2 = 32'hFFFF;
    step(1, 1);
    chk("sc5_disp", disp, 32'h1234);
    chk_ctrl("sc5", ST_RUN, 1'b0, 1'b0);

    bus.RD1 = 32'd1; bus.RD2 = 32'h42;
    step(1, 1);
    chk("sc1_disp", disp, 32'h42);

    bus.valid = 1'b0; bus.RD1 = 32'd10;
    step(1, 0);
    chk_ctrl("sc_invalid", ST_RUN, 1'b0, 1'b0);
    chk_cnt("sc_invalid");

    // pause held three cycles, then go
    idle();
    bus.valid = 1'b1; bus.SYSCALL = 1'b1; bus.RD1 = 32'd50; bus.RD2 = 32'h777;
    bus.RegWrite = 1'b1; bus.WbRegNum = 5'd4;
    step(1, 1);
    chk_ctrl("pause1", ST_PAUSE, 1'b1, 1'b0);
    chk("pause_we", 32'(rf_we), 32'h0);
    step(1, 0);
    step(1, 0);
    chk_ctrl("pause3", ST_PAUSE, 1'b1, 1'b0);
    chk_cnt("pause3");
    chk("pause_disp", disp, 32'h42);

    go = 1'b1;
    step(1, 0);
    chk_ctrl("resume", ST_RESUME, 1'b0, 1'b0);
    chk("resume_we", 32'(rf_we), 32'h0);
    step(1, 0);
    go = 1'b0;
    chk_ctrl("after_resume", ST_RUN, 1'b0, 1'b0);
    chk_cnt("after_resume");
    idle();

    // halt: terminal, counters frozen, go ignored
    bus.valid = 1'b1; bus.SYSCALL = 1'b1; bus.RD1 = 32'd10;
    step(1, 1);
    chk_ctrl("halt", ST_HALT, 1'b1, 1'b1);
    chk_cnt("halt");
    idle();
    bus.valid = 1'b1; bus.RegWrite = 1'b1; bus.WbRegNum = 5'd9;
    go = 1'b1;
    settle();
    chk("halt_we", 32'(rf_we), 32'h0);
    step(0, 0);
    step(0, 0);
    go = 1'b0;
    chk_ctrl("halt_go", ST_HALT, 1'b1, 1'b1);
    chk_cnt("halt_go");

    // reset wins over a full set of active inputs
    idle();
    bus.valid = 1'b1; bus.SYSCALL = 1'b1; bus.RD1 = 32'd34; bus.RD2 = 32'hBEEF;
    bus.LOWrite = 1'b1; bus.HIWrite = 1'b1; bus.R1 = 32'h11; bus.R2 = 32'h22;
    go = 1'b1;
    CLR = 1'b1;
    step(0, 0);
    exp_cyc = '0;
    exp_ret = '0;
    CLR = 1'b0;
    go  = 1'b0;
    idle();
    chk_ctrl("clr", ST_RUN, 1'b0, 1'b0);
    chk("clr_hi", hi, 32'h0);
    chk("clr_lo", lo, 32'h0);
    chk("clr_disp", disp, 32'h0);
    chk_cnt("clr");
    step(1, 0);
    chk_ctrl("post_clr", ST_RUN, 1'b0, 1'b0);
    chk_cnt("post_clr");

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 clk  in  1  sole clock; all state updates on posedge.
REQ-002 CLR  in  1  reset, synchronous, active-high.
REQ-003 valid  in  1  instruction present in WB (MEM/WB Out bit).
REQ-004 IR  in  32  instruction word; PC  in  32  instruction address.
REQ-005 R1  in  32  ALU result (low word for mult/div); R2  in  32  load data, or high word for mult/div.
REQ-006 RD1  in  32  $v0 value; RD2  in  32  $a0 value.
REQ-007 WbRegNum  in  5  destination register.
REQ-008 RegWrite, LOWrite, HIWrite, JAL, SYSCALL  in  1 each  WB controls.
REQ-009 go  in  1  operator continue pulse.
REQ-010 rf_we  out  1; rf_waddr  out  5; rf_wdata  out  32  register-file write port, combinational.
REQ-011 hi, lo  out  32 each  HI/LO registers.
REQ-012 disp  out  32  display latch; halt  out  1; stall  out  1  upstream freeze, drives EN low on all earlier pipeline registers.
REQ-013 retire_cnt, cycle_cnt  out  32 each  statistics counters.

Function
REQ-014 Live = valid AND state==RUN; every write, count and syscall action SHALL be gated by Live.
REQ-015 rf_we = Live AND RegWrite AND WbRegNum!=0; rf_waddr = WbRegNum.
REQ-016 rf_wdata priority: JAL -> PC+4; opcode 0x23 (lw) -> R2; opcode 0, funct 0x10 -> hi; opcode 0, funct 0x12 -> lo; else R1.
REQ-017 mfhi/mflo SHALL read registered hi/lo, i.e. values as of the previous edge.
REQ-018 LOWrite: lo <= R1; HIWrite: hi <= R2; both in one cycle are allowed and independent.
REQ-019 FSM states RUN, PAUSE, HALT, RESUME; encoding 2 bits.
REQ-020 RUN, Live AND SYSCALL: RD1==10 -> HALT; RD1==50 -> PAUSE; RD1==1 or 34 -> disp <= RD2, stay RUN; any other RD1 -> no effect.
REQ-021 PAUSE: go -> RESUME; else hold.
REQ-022 RESUME: one cycle, stall=0, WB inputs ignored (the held syscall is not re-executed); then RUN.
REQ-023 HALT: terminal until CLR; go ignored.
REQ-024 stall = 1 in PAUSE and HALT, else 0; halt = 1 in HALT only.
REQ-025 retire_cnt +1 per Live cycle, including the syscall that causes PAUSE/HALT.
REQ-026 cycle_cnt +1 in RUN, PAUSE and RESUME; frozen in HALT.
REQ-027 Both counters SHALL wrap modulo 2^32 without flagging.
REQ-028 go asserted while in RUN or RESUME SHALL have no effect.

Reset
REQ-029 CLR SHALL win over every other input on the same edge: state=RUN, hi=lo=disp=retire_cnt=cycle_cnt=0.
REQ-030 CLR mid-PAUSE or mid-HALT SHALL return to RUN on the next cycle with stall=0.

Structure
REQ-031 A shared package SHALL hold the opcode/funct constants (0x23, 0x10, 0x12), the syscall codes (1, 34, 10, 50) and the state encoding.
REQ-032 Sub-module wb_syscall_fsm SHALL contain the state register and the stall/halt decode; data muxing, HI/LO and counters stay in wb_stage.

Verification
REQ-033 lw: valid, RegWrite, WbRegNum=8, R2=0xDEADBEEF -> rf_we=1, rf_waddr=8, rf_wdata=0xDEADBEEF; repeated with WbRegNum=0 -> rf_we=0.
REQ-034 JAL at PC=0x00400010, WbRegNum=31 -> rf_wdata=0x00400014.
REQ-035 mult writes LO=5, HI=7 (R1=5, R2=7); next cycle mfhi -> rf_wdata=7, then mflo -> 5.
REQ-036 SYSCALL with RD1=34, RD2=0x1234 -> disp=0x1234 next cycle, state stays RUN.
REQ-037 SYSCALL with RD1=50, held 3 cycles -> stall=1, retire_cnt +1 once; go pulse -> one RESUME cycle with stall=0 and no second retire, then RUN.
REQ-038 SYSCALL with RD1=10 -> halt=1, cycle_cnt frozen, go ignored; CLR -> all outputs 0, state RUN.
